sram_responder: RTL and testbench
=================================

# sram_responder

Responder end of the CPU's single-port SRAM-style data interface (`we`/`addr`/`wdata`/`rdata`, no handshake, one-cycle read latency). Sits outside `mycpu_top` in the SoC and answers every access the CPU initiates: a word RAM region for program data plus a small MMIO region (LEDs, switches, free-running timer, error counter). Decodes the byte address, performs reads and writes, and flags accesses to unmapped addresses.

## Interface
- `ADDR_W`, 16, word-address bits of the RAM region (depth 2^ADDR_W words)
- `RAM_BASE`, 32'h1c00_0000, RAM region base; must be aligned to 2^(ADDR_W+2)
- `MMIO_BASE`, 32'hbfaf_0000, MMIO region base; 64 KiB aligned
- `clk`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `sram_we`  in  1  write strobe for this cycle's access
- `sram_addr`  in  32  byte address; bits [1:0] ignored (word access only)
- `sram_wdata`  in  32  write data
- `sram_rdata`  out  32  read data, registered, valid the cycle after the address
- `sw_in`  in  16  switch inputs, sampled at read
- `led_out`  out  16  LED register contents
- `err`  out  1  sticky: set by any unmapped access, cleared only by reset

## Operation
- Region decode (combinational on `sram_addr`):
  - RAM hit: `sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]`; word index `sram_addr[ADDR_W+1:2]`.
  - MMIO hit: `sram_addr[31:16] == MMIO_BASE[31:16]`; offset `sram_addr[15:0]`.
  - Otherwise unmapped.
- Every cycle is an access; there is no idle state. A read is implied when `sram_we`=0. A write cycle also produces `sram_rdata` (read-first).
- RAM: write stores `sram_wdata` at the edge. Read returns the contents before that edge's write (read-first). RAM contents are not reset.
- MMIO map (offset, access, behaviour):
  - 0x000 LED, RW: write sets `led_out` = `sram_wdata[15:0]`; read returns `{16'b0, led_out}`.
  - 0x004 SWITCH, RO: read returns `{16'b0, sw_in}`; writes are dropped, no error.
  - 0x008 TIMER, RW: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0. A write loads `sram_wdata`. Load wins over increment, and increment resumes the next cycle. A read returns the pre-edge value.
  - 0x00C ERRCNT, RO, 8-bit: counts unmapped accesses and saturates at 0xFF; read returns `{24'b0, errcnt}`.
  - Any other MMIO offset is treated as unmapped.
- Unmapped access: writes are dropped, `sram_rdata` is 0 the next cycle, `err` is set to 1, and ERRCNT increments (saturating).

## Timing
- Reset values (async, immediate on `resetn` low): `sram_rdata`=0, `led_out`=0, `err`=0, TIMER=0, ERRCNT=0.
- Read latency is exactly 1 cycle: address at edge N, data on `sram_rdata` after edge N+1 and held until the next edge.
- Write takes effect at edge N. A read of the same address in cycle N+1 returns the new data; no bypass is needed.
- Back-to-back accesses are accepted every cycle with no stall.
- Reset asserted mid-access: that cycle's write is lost. TIMER restarts from 0 after the release edge, counting from the first edge with `resetn`=1.
- `err` and the ERRCNT increment become visible the cycle after the offending access.

## Configuration
- `SRAM_RSP_TIMER_EN` defined: the TIMER register exists at MMIO offset 0x008 as specified above.
- `SRAM_RSP_TIMER_EN` undefined:
  - No counter flops.
  - Offset 0x008 decodes as unmapped: read returns 0, writes are dropped, and `err`/ERRCNT are updated.

## Test plan
- Reset, then read 0x1c00_0000: `sram_rdata`=0 and `err`=0 during reset. After release, write 0x1234_5678 to 0x1c00_0010 and read it next cycle → 0x1234_5678 one cycle later.
- Read-first: 0x1c00_0020 holds 0xAAAA_AAAA; write 0x5555_5555 there → `sram_rdata`=0xAAAA_AAAA next cycle; following read → 0x5555_5555.
- LED/switch: write 0x0001_00FF to 0xbfaf_0000 → `led_out`=0x00FF. Set `sw_in`=0xBEEF and read 0xbfaf_0004 → 0x0000_BEEF. A write to 0x004 leaves `err`=0.
- Timer (macro defined): write 0xFFFF_FFFE to 0xbfaf_0008, then read the next two cycles → 0xFFFF_FFFE, then 0xFFFF_FFFF; the third consecutive read → 0x0000_0000.
- Unmapped: write to 0x0000_0040 → no RAM change and `err`=1 next cycle. Repeat 300 unmapped reads, then read 0xbfaf_000c → 0x0000_00FF (saturated).
- Macro undefined: read 0xbfaf_0008 → `sram_rdata`=0 and `err`=1.

Source files
------------

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : Responder for the CPU single-port SRAM-style data bus: word RAM
//            plus MMIO (LED, switch, timer, error counter). Optional TIMER
//            register enabled by defining SRAM_RSP_TIMER_EN.
// Revision : 1.0  initial release
// ============================================================================
module sram_responder #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        err
);

  localparam int         c_RAM_DEPTH = 1 << ADDR_W;
  localparam logic [13:0] c_OFF_LED    = 14'd0;
  localparam logic [13:0] c_OFF_SW     = 14'd1;
  localparam logic [13:0] c_OFF_ECNT   = 14'd3;
`ifdef SRAM_RSP_TIMER_EN
  localparam logic [13:0] c_OFF_TIMER  = 14'd2;
`endif

  logic              w_ram_hit;
  logic              w_mmio_hit;
  logic [ADDR_W-1:0] w_word;
  logic [13:0]       w_off;
  logic              w_sel_led;
  logic              w_sel_sw;
  logic              w_sel_tmr;
  logic              w_sel_ecnt;
  logic              w_unmapped;
  logic [31:0]       w_mmio_rd;
  logic              w_unused_addr_bits;

  logic [31:0]       r_mem [c_RAM_DEPTH];
  logic [31:0]       r_ram_rd;
  logic              r_rd_ram_sel;
  logic [31:0]       r_mmio_rd;
  logic [15:0]       r_led;
  logic              r_err;
  logic [7:0]        r_errcnt;

  // Byte lane bits are never looked at: every access is a full word.
  assign w_unused_addr_bits = ^sram_addr[1:0];

  // RAM takes priority if a mis-configured base ever overlaps the MMIO window.
  assign w_ram_hit  = (sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
  assign w_mmio_hit = !w_ram_hit && (sram_addr[31:16] == MMIO_BASE[31:16]);
  assign w_word     = sram_addr[ADDR_W+1:2];
  assign w_off      = sram_addr[15:2];

  assign w_sel_led  = w_mmio_hit && (w_off == c_OFF_LED);
  assign w_sel_sw   = w_mmio_hit && (w_off == c_OFF_SW);
  assign w_sel_ecnt = w_mmio_hit && (w_off == c_OFF_ECNT);
`ifdef SRAM_RSP_TIMER_EN
  assign w_sel_tmr  = w_mmio_hit && (w_off == c_OFF_TIMER);
`else
  assign w_sel_tmr  = 1'b0;
`endif

  assign w_unmapped = !(w_ram_hit || w_sel_led || w_sel_sw || w_sel_tmr || w_sel_ecnt);

  // RAM array has no reset; a write on a cycle that sees reset is dropped.
  always_ff @(posedge clk) begin
    r_ram_rd <= r_mem[w_word];
    if (resetn && sram_we && w_ram_hit) begin
      r_mem[w_word] <= sram_wdata;
    end
  end

`ifdef SRAM_RSP_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= 32'd0;
    end else if (w_sel_tmr && sram_we) begin
      r_timer <= sram_wdata;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  always_comb begin
    w_mmio_rd = 32'd0;
    if (w_sel_led) begin
      w_mmio_rd = {16'd0, r_led};
    end
    if (w_sel_sw) begin
      w_mmio_rd = {16'd0, sw_in};
    end
`ifdef SRAM_RSP_TIMER_EN
    if (w_sel_tmr) begin
      w_mmio_rd = r_timer;
    end
`endif
    if (w_sel_ecnt) begin
      w_mmio_rd = {24'd0, r_errcnt};
    end
  end

  // Non-RAM read data (zero for unmapped) is captured alongside the RAM select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ram_sel <= 1'b0;
      r_mmio_rd    <= 32'd0;
    end else begin
      r_rd_ram_sel <= w_ram_hit;
      r_mmio_rd    <= w_mmio_rd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= 16'd0;
    end else if (w_sel_led && sram_we) begin
      r_led <= sram_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err    <= 1'b0;
      r_errcnt <= 8'd0;
    end else if (w_unmapped) begin
      r_err <= 1'b1;
      if (r_errcnt != 8'hFF) begin
        r_errcnt <= r_errcnt + 8'd1;
      end
    end
  end

  assign sram_rdata = r_rd_ram_sel ? r_ram_rd : r_mmio_rd;
  assign led_out    = r_led;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Purpose  : Directed self-checking bench for sram_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_responder;

  logic        clk;
  logic        resetn;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        err;

  int errors = 0;
  int checks = 0;

  sram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, take the edge, settle 1 time unit past it.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    sram_we    = we;
    sram_addr  = a;
    sram_wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    resetn     = 1'b1;
    sram_we    = 1'b0;
    sram_addr  = 32'h1c00_0000;
    sram_wdata = 32'd0;
    sw_in      = 16'd0;
    #2 resetn  = 1'b0;
    #1;
    check("reset_rdata", sram_rdata, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_led", {16'd0, led_out}, 32'd0);
    step(1'b0, 32'h1c00_0000, 32'd0);
    check("reset_read_rdata", sram_rdata, 32'd0);
    check("reset_read_err", {31'd0, err}, 32'd0);
    resetn = 1'b1;

    // Write then read back
    step(1'b1, 32'h1c00_0010, 32'h1234_5678);
    step(1'b0, 32'h1c00_0010, 32'd0);
    check("ram_wr_rd", sram_rdata, 32'h1234_5678);
    step(1'b0, 32'h1c00_0013, 32'd0);
    check("ram_byte_bits_ignored", sram_rdata, 32'h1234_5678);
    step(1'b1, 32'h1c00_0040, 32'h0BAD_F00D);

    // Read-first
    step(1'b1, 32'h1c00_0020, 32'hAAAA_AAAA);
    step(1'b1, 32'h1c00_0020, 32'h5555_5555);
    check("ram_read_first", sram_rdata, 32'hAAAA_AAAA);
    step(1'b0, 32'h1c00_0020, 32'd0);
    check("ram_new_data", sram_rdata, 32'h5555_5555);

    // LED and switch
    step(1'b1, 32'hbfaf_0000, 32'h0001_00FF);
    check("led_out", {16'd0, led_out}, 32'h0000_00FF);
    step(1'b0, 32'hbfaf_0000, 32'd0);
    check("led_read", sram_rdata, 32'h0000_00FF);
    sw_in = 16'hBEEF;
    step(1'b0, 32'hbfaf_0004, 32'd0);
    check("sw_read", sram_rdata, 32'h0000_BEEF);
    step(1'b1, 32'hbfaf_0004, 32'hFFFF_FFFF);
    check("sw_write_no_err", {31'd0, err}, 32'd0);
    step(1'b0, 32'hbfaf_0004, 32'd0);
    check("sw_write_dropped", sram_rdata, 32'h0000_BEEF);
    check("led_unchanged", {16'd0, led_out}, 32'h0000_00FF);
    step(1'b0, 32'hbfaf_000c, 32'd0);
    check("errcnt_zero", sram_rdata, 32'd0);

    // Timer
`ifdef SRAM_RSP_TIMER_EN
    step(1'b1, 32'hbfaf_0008, 32'hFFFF_FFFE);
    step(1'b0, 32'hbfaf_0008, 32'd0);
    check("timer_load", sram_rdata, 32'hFFFF_FFFE);
    step(1'b0, 32'hbfaf_0008, 32'd0);
    check("timer_inc", sram_rdata, 32'hFFFF_FFFF);
    step(1'b0, 32'hbfaf_0008, 32'd0);
    check("timer_wrap", sram_rdata, 32'h0000_0000);
    check("timer_no_err", {31'd0, err}, 32'd0);
    exp_cnt = 32'd2;
`else
    step(1'b0, 32'hbfaf_0008, 32'd0);
    check("timer_absent_rdata", sram_rdata, 32'd0);
    check("timer_absent_err", {31'd0, err}, 32'd1);
    exp_cnt = 32'd3;
`endif

    // Unmapped accesses
    step(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    check("unmapped_err", {31'd0, err}, 32'd1);
    check("unmapped_rdata", sram_rdata, 32'd0);
    step(1'b0, 32'h1c00_0040, 32'd0);
    check("unmapped_no_ram_write", sram_rdata, 32'h0BAD_F00D);
    step(1'b0, 32'hbfaf_0010, 32'd0);
    check("mmio_hole_rdata", sram_rdata, 32'd0);
    step(1'b0, 32'hbfaf_000c, 32'd0);
    check("errcnt_count", sram_rdata, exp_cnt);
    check("err_sticky", {31'd0, err}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 32'h0000_1000 + 32'(i * 4), 32'd0);
    end
    check("unmapped_loop_rdata", sram_rdata, 32'd0);
    step(1'b0, 32'hbfaf_000c, 32'd0);
    check("errcnt_saturated", sram_rdata, 32'h0000_00FF);

    // Reset during a write cycle
    sram_we    = 1'b1;
    sram_addr  = 32'h1c00_0010;
    sram_wdata = 32'h0000_CAFE;
    resetn     = 1'b0;
    #1;
    check("midreset_err", {31'd0, err}, 32'd0);
    check("midreset_led", {16'd0, led_out}, 32'd0);
    check("midreset_rdata", sram_rdata, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
`ifdef SRAM_RSP_TIMER_EN
    step(1'b0, 32'hbfaf_0008, 32'd0);
    check("timer_after_reset", sram_rdata, 32'd0);
`endif
    step(1'b0, 32'hbfaf_000c, 32'd0);
    check("errcnt_after_reset", sram_rdata, 32'd0);
    step(1'b0, 32'h1c00_0010, 32'd0);
    check("write_lost_in_reset", sram_rdata, 32'h1234_5678);
    check("err_after_reset", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
